// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester line encoder: valid/ready word input, framed as preamble + MSB-first data + idle-low gap.
// A 1 is sent high->low, a 0 low->high; every bit lasts exactly BIT_LENGTH clocks.
module tt_um_hoene_manchester_encoder #(
    parameter int BIT_LENGTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_BITS  = 2,
    parameter int GAP_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out,
    output logic                  out_active,
    output logic                  out_error
);

    localparam int HALF     = BIT_LENGTH / 2;
    localparam int MAX_SD   = (SYNC_BITS > DATA_WIDTH) ? SYNC_BITS : DATA_WIDTH;
    localparam int MAX_BITS = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [4:0]       HALF_LAST = 5'(HALF - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

    // state | meaning
    localparam logic [1:0] ST_IDLE = 2'd0;  // line low, waiting for a word
    localparam logic [1:0] ST_SYNC = 2'd1;  // alternating 1,0,... preamble
    localparam logic [1:0] ST_DATA = 2'd2;  // payload, MSB first
    localparam logic [1:0] ST_GAP  = 2'd3;  // idle-low bit periods

    if ((BIT_LENGTH % 2) != 0 || BIT_LENGTH < 4 || BIT_LENGTH > 62) begin : g_bad_bit_length
        $fatal(1, "BIT_LENGTH must be even and within 4..62");
    end
    if (SYNC_BITS < 2) begin : g_bad_sync_bits
        $fatal(1, "SYNC_BITS must be at least 2");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_data_width
        $fatal(1, "DATA_WIDTH must be within 1..32");
    end
    if (GAP_BITS < 1) begin : g_bad_gap_bits
        $fatal(1, "GAP_BITS must be at least 1");
    end

    logic [1:0]            state;
    logic [4:0]            half_cnt;
    logic                  phase;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] next_shreg;
    logic                  prev_valid;
    logic                  prev_accept;
    logic [DATA_WIDTH-1:0] prev_data;

    logic accept;
    logic half_end;
    logic cur_bit;
    logic waiting;
    logic err_now;

    assign in_ready   = (state == ST_IDLE) && rst_n;
    assign accept     = in_valid && in_ready;
    assign half_end   = (half_cnt == HALF_LAST);
    assign next_shreg = shreg << 1;

    always_comb begin
        cur_bit = 1'b0;
        if (state == ST_SYNC) begin
            cur_bit = ~bit_cnt[0];
        end else if (state == ST_DATA) begin
            cur_bit = shreg[DATA_WIDTH-1];
        end
    end

    // A producer stalled by in_ready must hold valid and data; the cycle after an accept may present a new word.
    assign waiting = prev_valid && !prev_accept;
    assign err_now = !in_ready &&
                     ((in_valid && !prev_valid) ||
                      (waiting && !in_valid) ||
                      (waiting && in_valid && (in_data != prev_data)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            half_cnt    <= '0;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            out         <= 1'b0;
            out_active  <= 1'b0;
            out_error   <= 1'b0;
            prev_valid  <= 1'b0;
            prev_accept <= 1'b0;
            prev_data   <= '0;
        end else begin
            prev_valid  <= in_valid;
            prev_accept <= accept;
            prev_data   <= in_data;
            if (err_now) begin
                out_error <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    out        <= 1'b0;
                    out_active <= 1'b0;
                    half_cnt   <= '0;
                    phase      <= 1'b0;
                    bit_cnt    <= '0;
                    if (accept) begin
                        state      <= ST_SYNC;
                        shreg      <= in_data;
                        out        <= 1'b1;
                        out_active <= 1'b1;
                    end
                end

                ST_SYNC, ST_DATA: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt + 5'd1;
                    end else begin
                        half_cnt <= '0;
                        phase    <= ~phase;
                        if (!phase) begin
                            out <= ~cur_bit;
                        end else if (state == ST_SYNC) begin
                            if (bit_cnt == SYNC_LAST) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                                out     <= shreg[DATA_WIDTH-1];
                            end else begin
                                // Next preamble bit k+1 has value ~(k+1)[0], i.e. k[0].
                                bit_cnt <= bit_cnt + 1'b1;
                                out     <= bit_cnt[0];
                            end
                        end else begin
                            shreg <= next_shreg;
                            if (bit_cnt == DATA_LAST) begin
                                state      <= ST_GAP;
                                bit_cnt    <= '0;
                                out        <= 1'b0;
                                out_active <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                out     <= next_shreg[DATA_WIDTH-1];
                            end
                        end
                    end
                end

                ST_GAP: begin
                    out        <= 1'b0;
                    out_active <= 1'b0;
                    if (!half_end) begin
                        half_cnt <= half_cnt + 5'd1;
                    end else begin
                        half_cnt <= '0;
                        phase    <= ~phase;
                        if (phase) begin
                            if (bit_cnt == GAP_LAST) begin
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
